// File: rtl/alu_exec.sv
// Handshaked 32-bit ALU with registered result; variable shifts run 1 bit/cycle in SHIFT.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.

`ifndef ALU_ADD
`define ALU_ADD  4'h0
`define ALU_SUB  4'h1
`define ALU_AND  4'h2
`define ALU_OR   4'h3
`define ALU_XOR  4'h4
`define ALU_NOR  4'h5
`define ALU_SLT  4'h6
`define ALU_SLLV 4'h7
`define ALU_SRLV 4'h8
`define ALU_LU   4'h9
`endif

module alu_exec (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  cmd,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        illegal,
    output logic        busy
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] work_q;
    logic        dir_right_q;
    logic        out_valid_q;
    logic [31:0] result_q;
    logic        zero_q;
    logic        overflow_q;
    logic        illegal_q;

    logic        accept;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] alu_res;
    logic        alu_ovf;
    logic        alu_ill;
    logic        is_shift;
    logic        start_shift;
    logic [31:0] work_next;

    assign in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign sum       = a + b;
    assign diff      = a - b;
    assign work_next = dir_right_q ? {1'b0, work_q[31:1]} : {work_q[30:0], 1'b0};

    always_comb begin
        alu_res  = '0;
        alu_ovf  = 1'b0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        case (cmd)
            `ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            `ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            `ALU_AND: alu_res = a & b;
            `ALU_OR:  alu_res = a | b;
            `ALU_XOR: alu_res = a ^ b;
            `ALU_NOR: alu_res = ~(a | b);
            `ALU_SLT: alu_res = {31'b0, ($signed(a) < $signed(b))};
            `ALU_LU:  alu_res = {b[15:0], 16'h0000};
`ifdef ALU_FAST_SHIFT_EN
            `ALU_SLLV: begin
                alu_res  = b << a[4:0];
                is_shift = 1'b1;
            end
            `ALU_SRLV: begin
                alu_res  = b >> a[4:0];
                is_shift = 1'b1;
            end
`else
            // Only the zero-amount case completes here; longer shifts go through SHIFT.
            `ALU_SLLV: begin
                alu_res  = b;
                is_shift = 1'b1;
            end
            `ALU_SRLV: begin
                alu_res  = b;
                is_shift = 1'b1;
            end
`endif
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN
    assign start_shift = 1'b0;
`else
    assign start_shift = is_shift && (a[4:0] != 5'd0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            work_q      <= '0;
            dir_right_q <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept && start_shift) begin
                        state_q     <= StShift;
                        cnt_q       <= a[4:0];
                        work_q      <= b;
                        dir_right_q <= (cmd == `ALU_SRLV);
                        out_valid_q <= 1'b0;
                    end else if (accept) begin
                        result_q    <= alu_res;
                        zero_q      <= (alu_res == 32'd0);
                        overflow_q  <= alu_ovf;
                        illegal_q   <= alu_ill;
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                StShift: begin
                    work_q <= work_next;
                    cnt_q  <= cnt_q - 5'd1;
                    // Last step: the counter reaches zero on this edge.
                    if (cnt_q == 5'd1) begin
                        state_q     <= StIdle;
                        result_q    <= work_next;
                        zero_q      <= (work_next == 32'd0);
                        overflow_q  <= 1'b0;
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;
    assign busy      = (state_q == StShift);

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: driver queues hand-computed results, monitor checks each handshake.

`ifndef ALU_ADD
`define ALU_ADD  4'h0
`define ALU_SUB  4'h1
`define ALU_AND  4'h2
`define ALU_OR   4'h3
`define ALU_XOR  4'h4
`define ALU_NOR  4'h5
`define ALU_SLT  4'h6
`define ALU_SLLV 4'h7
`define ALU_SRLV 4'h8
`define ALU_LU   4'h9
`endif

module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  cmd = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;
    logic        busy;

    alu_exec dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmd       (cmd),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        il;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    exp_t mon_got;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_res = 0;

`ifdef ALU_FAST_SHIFT_EN
    localparam int ExpShiftLat  = 0;
    localparam int ExpShiftBusy = 0;
    localparam bit PushAborted  = 1'b1;
`else
    localparam int ExpShiftLat  = 4;
    localparam int ExpShiftBusy = 4;
    localparam bit PushAborted  = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A handshake seen at negedge completes on the following posedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_got = {result, zero, overflow, illegal};
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: got res=%h with nothing expected", result);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    n_err++;
                    $display("FAIL result_%0d: got res=%h z=%b ov=%b il=%b expected res=%h z=%b ov=%b il=%b",
                             n_res, mon_got.res, mon_got.z, mon_got.ov, mon_got.il,
                             mon_exp.res, mon_exp.z, mon_exp.ov, mon_exp.il);
                end
            end
            n_res++;
        end
    end

    task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic ez, input logic eov,
                         input logic eil, input bit push);
        logic rdy;
        int   k;
        cmd      = c;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        rdy      = 1'b0;
        k        = 0;
        while (!rdy && k < 100) begin
            @(negedge clk);
            rdy = in_ready;
            if (rdy && push) sb.push_back({er, ez, eov, eil});
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        if (!rdy) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 for 100 cycles expected 1");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int busy_cnt;
        int ov_cnt;

        #7;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {29'd0, zero, overflow, illegal}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;

        issue(`ALU_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("add_latency", 32'(out_valid), 32'd1);
        issue(`ALU_SUB, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(`ALU_SLT, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(`ALU_SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(`ALU_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(`ALU_AND, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(`ALU_OR, 32'h0000FF00, 32'h00F000F0, 32'h00F0FFF0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(`ALU_NOR, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(`ALU_SLT, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(`ALU_LU, 32'h0000DEAD, 32'hABCD5678, 32'h56780000, 1'b0, 1'b0, 1'b0, 1'b1);

        // SLLV by 4: count edges after acceptance until out_valid appears
        issue(`ALU_SLLV, 32'd4, 32'h3, 32'h30, 1'b0, 1'b0, 1'b0, 1'b1);
        lat      = 0;
        busy_cnt = 0;
        while (!out_valid && lat < 50) begin
            if (busy && !in_ready) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("sllv_latency", lat, ExpShiftLat);
        chk("sllv_busy_cycles", busy_cnt, ExpShiftBusy);

        issue(`ALU_SLLV, 32'h20, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sllv_zero_amt_latency", 32'(out_valid), 32'd1);
        issue(`ALU_SRLV, 32'd31, 32'h80000000, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(`ALU_SRLV, 32'd8, 32'h12345678, 32'h00123456, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(`ALU_SLLV, 32'd31, 32'h3, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back XORs with the consumer stalled after the first
        repeat (40) begin
            if (!out_valid && !busy) break;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        issue(`ALU_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0, 1'b0, 1'b1);
        fork
            issue(`ALU_XOR, 32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987, 1'b0, 1'b0, 1'b0, 1'b1);
            begin
                repeat (3) begin
                    chk("stall_result", result, 32'hFF00FF00);
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        issue(`ALU_XOR, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset during a long shift aborts it; a nonzero result is left registered first
        issue(`ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(`ALU_SRLV, 32'd31, 32'h80000000, 32'h1, 1'b0, 1'b0, 1'b0, PushAborted);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_flags", {29'd0, zero, overflow, illegal}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        ov_cnt = 0;
        repeat (40) begin
            if (out_valid) ov_cnt++;
            @(posedge clk);
            #1;
        end
        chk("abort_no_result", ov_cnt, 0);
        issue(`ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);

        issue(4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("illegal_flag", 32'(illegal), 32'd1);
        issue(`ALU_LU, 32'h0, 32'h00001234, 32'h12340000, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lu_illegal_clear", 32'(illegal), 32'd0);

        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The module SHALL have port in_valid, input, 1 bit: an operation is presented on cmd/a/b.
REQ-004 The module SHALL have port in_ready, output, 1 bit: the module can accept an operation this cycle.
REQ-005 The module SHALL have port cmd, input, 4 bits: ALU command, encoded with the shared ALU_* macros (ADD, SUB, AND, OR, XOR, NOR, SLT, SLLV, SRLV, LU).
REQ-006 The module SHALL have ports a and b, input, 32 bits each: operands.
REQ-007 The module SHALL have port out_valid, output, 1 bit: the result registers hold a valid result.
REQ-008 The module SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-009 The module SHALL have port result, output, 32 bits: the registered result.
REQ-010 The module SHALL have port zero, output, 1 bit: result equals 0.
REQ-011 The module SHALL have port overflow, output, 1 bit: signed overflow on ADD/SUB.
REQ-012 The module SHALL have port illegal, output, 1 bit: cmd was not a defined ALU_* code.
REQ-013 The module SHALL have port busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-014 An operation SHALL be accepted on a rising edge where in_valid && in_ready; cmd, a and b are captured at that edge.
REQ-015 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-016 The FSM SHALL have states IDLE and SHIFT; non-shift ops and zero-amount shifts stay in IDLE; SLLV/SRLV with amount n>0 enter SHIFT.
REQ-017 Non-shift ops SHALL load result/flags and set out_valid at the accepting edge (latency 1).
REQ-018 ADD/SUB SHALL be 32-bit modulo; overflow = signed overflow; overflow=0 for every other cmd.
REQ-019 AND/OR/XOR/NOR SHALL be bitwise a op b.
REQ-020 SLT SHALL give {31'b0, $signed(a)<$signed(b)}.
REQ-021 LU SHALL give {b[15:0],16'h0000}.
REQ-022 SLLV/SRLV SHALL shift b (logical, zero fill) by n=a[4:0].
REQ-023 In SHIFT the module SHALL shift a working register 1 bit per cycle and decrement a 5-bit counter; on the edge the counter reaches 0, result loads, out_valid sets and the FSM returns to IDLE, giving out_valid n edges after the accepting edge.
REQ-024 An undefined cmd SHALL give result=0, illegal=1, latency 1; illegal=0 for defined cmds.
REQ-025 zero SHALL be the registered (result==0).
REQ-026 While out_valid && !out_ready, result, zero, overflow, illegal and out_valid SHALL hold stable.
REQ-027 out_valid SHALL clear on an edge with out_ready=1 unless a new op completes at that same edge (back-to-back, 1 result/cycle for latency-1 ops).
REQ-028 Inputs presented while in_ready=0 SHALL be ignored.

Reset
REQ-029 When rst is high, regardless of clk: state=IDLE, counter=0, out_valid=0, result=0, zero=0, overflow=0, illegal=0, busy=0.
REQ-030 Reset asserted during SHIFT SHALL abort the operation with no result produced; in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-031 With ALU_FAST_SHIFT_EN defined, SLLV/SRLV SHALL use a combinational barrel shifter with latency 1, the SHIFT state is never entered, and busy stays 0.
REQ-032 With ALU_FAST_SHIFT_EN undefined, shifts SHALL follow REQ-023; results are identical in both builds, only latency differs.

Verification
REQ-033 ADD a=32'h7FFFFFFF b=1, out_ready=1 -> one edge later result=32'h80000000, overflow=1, zero=0.
REQ-034 SUB a=5 b=5 -> result=0, zero=1, overflow=0; SLT a=32'hFFFFFFFF b=1 -> result=1.
REQ-035 SLLV a=4 b=32'h00000003 (iterative build) -> busy=1, in_ready=0 for 4 cycles, out_valid on 4th edge, result=32'h00000030; fast build -> result after 1 edge.
REQ-036 Three back-to-back XOR ops with out_ready held 0 after first -> first result holds stable, in_ready=0 until out_ready=1, no op lost or duplicated.
REQ-037 SRLV a=31 b=32'h80000000, rst pulsed at cycle 10 -> all outputs 0 immediately, no out_valid; next ADD 2+3 -> result=5.
REQ-038 Undefined cmd code, a=b=32'hFFFFFFFF -> result=0, illegal=1, zero=1; following LU b=32'h00001234 -> result=32'h12340000, illegal=0.
